// File: rtl/accel_seq_loader_pkg.sv
// Shared types and constants for the accelerator sequence loader.
// State encoding, accelerator window bases and word counts.
package accel_seq_loader_pkg;

  localparam int N          = 8;
  localparam int WORDS      = N * N;
  localparam int LOAD_WORDS = 2 * WORDS;
  localparam int TIMEOUT    = 255;
  localparam int AW         = 10;
  localparam int DW         = 32;
  localparam int CNT_W      = 8;

  localparam logic [AW-1:0] A_BASE = 10'd128;
  localparam logic [AW-1:0] B_BASE = 10'd192;
  localparam logic [AW-1:0] C_BASE = 10'd256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_READ,
    ST_DONE
  } state_t;

  // Issue index -> accelerator word address (A words then B words)
  function automatic logic [AW-1:0] ab_addr(input logic [6:0] i);
    if (int'(i) < WORDS)
      return A_BASE + AW'(i);
    else
      return B_BASE + AW'(int'(i) - WORDS);
  endfunction

endpackage

// File: rtl/accel_seq_pipe.sv
// One-stage delay register with valid bit.
// Ports: clk, rst_n, in_valid/in_data -> out_valid/out_data (payload zeroed when invalid).
module accel_seq_pipe #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      out_data  <= in_valid ? in_data : '0;
    end
  end

endmodule

// File: rtl/accel_seq_loader.sv
// Copies A/B from source memory into the accelerator, waits for ready, drains C to dest.
// Ports: start/src_base/dst_base in; src_*, acc_*, dst_* buses; busy/done/err status.
module accel_seq_loader
  import accel_seq_loader_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  output logic          src_rd,
  output logic [AW-1:0] src_addr,
  input  logic [DW-1:0] src_data,
  output logic          acc_select,
  output logic          acc_wr_en,
  output logic [AW-1:0] acc_addr,
  output logic [DW-1:0] acc_wdata,
  input  logic [DW-1:0] acc_rdata,
  input  logic          acc_ready,
  output logic          dst_wr,
  output logic [AW-1:0] dst_addr,
  output logic [DW-1:0] dst_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t state, state_d;

  logic [CNT_W-1:0] cnt, cnt_d;
  logic [AW-1:0]    sbase_q, dbase_q;
  logic             err_q, err_d;

  logic             issue;
  logic             rd_issue;

  logic             lp_valid;
  logic [AW-1:0]    lp_addr;
  logic             rp_valid;
  logic [AW+DW-1:0] rp_data;

  assign issue    = (state == ST_LOAD)
                 && (cnt < CNT_W'(LOAD_WORDS));
  assign rd_issue = (state == ST_READ)
                 && (cnt < CNT_W'(WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      err_q   <= 1'b0;
      sbase_q <= '0;
      dbase_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      err_q <= err_d;
      if (state == ST_IDLE && start) begin
        sbase_q <= src_base;
        dbase_q <= dst_base;
      end
    end
  end

  always_comb begin
    state_d = state;
    err_d   = err_q;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        // extra cycle drains the final write
        if (cnt == CNT_W'(LOAD_WORDS))
          state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (acc_ready) begin
          state_d = ST_READ;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_READ: begin
        if (cnt == CNT_W'(WORDS))
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // counter restarts at 0 on every state entry
  always_comb begin
    cnt_d = '0;
    if (state_d == state && state != ST_IDLE)
      cnt_d = cnt + 1'b1;
  end

  accel_seq_pipe #(.W(AW)) u_load_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue),
    .in_data   (ab_addr(cnt[6:0])),
    .out_valid (lp_valid),
    .out_data  (lp_addr)
  );

  accel_seq_pipe #(.W(AW + DW)) u_read_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_issue),
    .in_data   ({dbase_q + AW'(cnt), acc_rdata}),
    .out_valid (rp_valid),
    .out_data  (rp_data)
  );

  always_comb begin
    src_rd   = issue;
    src_addr = issue ? sbase_q + AW'(cnt) : '0;
  end

  always_comb begin
    acc_select = 1'b0;
    acc_wr_en  = 1'b0;
    acc_addr   = '0;
    acc_wdata  = '0;
    if (state == ST_LOAD && lp_valid) begin
      acc_select = 1'b1;
      acc_wr_en  = 1'b1;
      acc_addr   = lp_addr;
      acc_wdata  = src_data;
    end else if (rd_issue) begin
      acc_select = 1'b1;
      acc_addr   = C_BASE + AW'(cnt);
    end
  end

  assign dst_wr   = rp_valid;
  assign dst_addr = rp_data[AW+DW-1:DW];
  assign dst_data = rp_data[DW-1:0];

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign err  = err_q;

endmodule
